// File: rtl/ic0_bus_arbiter_if.sv
// Bundle of the two master request ports and the shared ic0 slave bus.
// The arbiter takes the slave modport; the requesters and slaves sit on the master modport.
interface ic0_bus_arbiter_if;
  logic        m0_c_wr_valid;
  logic        m1_c_wr_valid;
  logic        m0_c_rd_valid;
  logic        m1_c_rd_valid;
  logic [31:0] m0_wr_addr;
  logic [31:0] m1_wr_addr;
  logic [31:0] m0_wr_data;
  logic [31:0] m1_wr_data;
  logic [31:0] m0_rd_addr;
  logic [31:0] m1_rd_addr;
  logic        m0_c_ack;
  logic        m1_c_ack;
  logic        m0_c_err;
  logic        m1_c_err;
  logic [31:0] m0_rd_data;
  logic [31:0] m1_rd_data;

  logic        ic0_c_axi_mst_wr_valid;
  logic        ic0_c_axi_mst_rd_valid;
  logic [31:0] ic0_axi_mst_wr_addr;
  logic [31:0] ic0_axi_mst_wr_data;
  logic [31:0] ic0_axi_mst_rd_addr;
  logic        ic0_c_axi_slv_rd_ready_0;
  logic        ic0_c_axi_slv_rd_ready_1;
  logic        ic0_c_axi_slv_rd_ready_2;
  logic        ic0_c_axi_slv_rd_ready_3;
  logic [31:0] ic0_axi_slv_rd_data_0;
  logic [31:0] ic0_axi_slv_rd_data_1;
  logic [31:0] ic0_axi_slv_rd_data_2;
  logic [31:0] ic0_axi_slv_rd_data_3;

  modport slave (
    input  m0_c_wr_valid, m1_c_wr_valid, m0_c_rd_valid, m1_c_rd_valid,
    input  m0_wr_addr, m1_wr_addr, m0_wr_data, m1_wr_data,
    input  m0_rd_addr, m1_rd_addr,
    output m0_c_ack, m1_c_ack, m0_c_err, m1_c_err, m0_rd_data, m1_rd_data,
    output ic0_c_axi_mst_wr_valid, ic0_c_axi_mst_rd_valid,
    output ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data, ic0_axi_mst_rd_addr,
    input  ic0_c_axi_slv_rd_ready_0, ic0_c_axi_slv_rd_ready_1,
    input  ic0_c_axi_slv_rd_ready_2, ic0_c_axi_slv_rd_ready_3,
    input  ic0_axi_slv_rd_data_0, ic0_axi_slv_rd_data_1,
    input  ic0_axi_slv_rd_data_2, ic0_axi_slv_rd_data_3
  );

  modport master (
    output m0_c_wr_valid, m1_c_wr_valid, m0_c_rd_valid, m1_c_rd_valid,
    output m0_wr_addr, m1_wr_addr, m0_wr_data, m1_wr_data,
    output m0_rd_addr, m1_rd_addr,
    input  m0_c_ack, m1_c_ack, m0_c_err, m1_c_err, m0_rd_data, m1_rd_data,
    input  ic0_c_axi_mst_wr_valid, ic0_c_axi_mst_rd_valid,
    input  ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data, ic0_axi_mst_rd_addr,
    output ic0_c_axi_slv_rd_ready_0, ic0_c_axi_slv_rd_ready_1,
    output ic0_c_axi_slv_rd_ready_2, ic0_c_axi_slv_rd_ready_3,
    output ic0_axi_slv_rd_data_0, ic0_axi_slv_rd_data_1,
    output ic0_axi_slv_rd_data_2, ic0_axi_slv_rd_data_3
  );
endinterface

// File: rtl/ic0_bus_arbiter.sv
// Round-robin arbiter sharing the ic0 slave bus between m0 (core LSU) and m1 (debug/loader),
// with slave-select decode on the read path and a read timeout returning ERR_DATA.
module ic0_bus_arbiter #(
  parameter int unsigned SEL_LSB  = 28,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              c_sys_rst,
  ic0_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_last_grant;
  logic        r_owner;
  logic [1:0]  r_sel;
  logic [7:0]  r_cnt;
  logic        r_wr_valid;
  logic        r_rd_valid;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic [31:0] r_rd_addr;
  logic        r_m0_ack;
  logic        r_m1_ack;
  logic        r_m0_err;
  logic        r_m1_err;
  logic [31:0] r_m0_rd_data;
  logic [31:0] r_m1_rd_data;

  state_t      w_state;
  logic        w_last_grant;
  logic        w_owner;
  logic [1:0]  w_sel;
  logic [7:0]  w_cnt;
  logic        w_wr_valid;
  logic        w_rd_valid;
  logic [31:0] w_wr_addr;
  logic [31:0] w_wr_data;
  logic [31:0] w_rd_addr;
  logic        w_m0_ack;
  logic        w_m1_ack;
  logic        w_m0_err;
  logic        w_m1_err;
  logic [31:0] w_m0_rd_data;
  logic [31:0] w_m1_rd_data;

  logic        w_req0;
  logic        w_req1;
  logic        w_grant1;
  logic        w_win_wr;
  logic [31:0] w_win_wr_addr;
  logic [31:0] w_win_wr_data;
  logic [31:0] w_win_rd_addr;
  logic        w_slv_ready;
  logic [31:0] w_slv_data;

  // A master whose read ack is on the bus this cycle is still holding its request;
  // masking it here keeps that stale request from being granted a second time.
  assign w_req0   = (bus.m0_c_wr_valid | bus.m0_c_rd_valid) & ~r_m0_ack;
  assign w_req1   = (bus.m1_c_wr_valid | bus.m1_c_rd_valid) & ~r_m1_ack;
  assign w_grant1 = w_req1 & (~w_req0 | ~r_last_grant);

  assign w_win_wr      = w_grant1 ? bus.m1_c_wr_valid : bus.m0_c_wr_valid;
  assign w_win_wr_addr = w_grant1 ? bus.m1_wr_addr    : bus.m0_wr_addr;
  assign w_win_wr_data = w_grant1 ? bus.m1_wr_data    : bus.m0_wr_data;
  assign w_win_rd_addr = w_grant1 ? bus.m1_rd_addr    : bus.m0_rd_addr;

  always_comb begin
    w_slv_ready = 1'b0;
    w_slv_data  = '0;
    unique case (r_sel)
      2'd0: begin w_slv_ready = bus.ic0_c_axi_slv_rd_ready_0; w_slv_data = bus.ic0_axi_slv_rd_data_0; end
      2'd1: begin w_slv_ready = bus.ic0_c_axi_slv_rd_ready_1; w_slv_data = bus.ic0_axi_slv_rd_data_1; end
      2'd2: begin w_slv_ready = bus.ic0_c_axi_slv_rd_ready_2; w_slv_data = bus.ic0_axi_slv_rd_data_2; end
      2'd3: begin w_slv_ready = bus.ic0_c_axi_slv_rd_ready_3; w_slv_data = bus.ic0_axi_slv_rd_data_3; end
      default: begin w_slv_ready = 1'b0; w_slv_data = '0; end
    endcase
  end

  always_comb begin
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_owner      = r_owner;
    w_sel        = r_sel;
    w_cnt        = r_cnt;
    w_wr_valid   = r_wr_valid;
    w_rd_valid   = r_rd_valid;
    w_wr_addr    = r_wr_addr;
    w_wr_data    = r_wr_data;
    w_rd_addr    = r_rd_addr;
    w_m0_rd_data = r_m0_rd_data;
    w_m1_rd_data = r_m1_rd_data;
    w_m0_ack     = 1'b0;
    w_m1_ack     = 1'b0;
    w_m0_err     = 1'b0;
    w_m1_err     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_req0 | w_req1) begin
          w_owner      = w_grant1;
          w_last_grant = w_grant1;
          if (w_win_wr) begin
            // Ack is registered together with the strobe so it lands in the WR cycle.
            w_state    = WR;
            w_wr_valid = 1'b1;
            w_wr_addr  = w_win_wr_addr;
            w_wr_data  = w_win_wr_data;
            w_m0_ack   = ~w_grant1;
            w_m1_ack   = w_grant1;
          end else begin
            w_state    = RD_WAIT;
            w_rd_valid = 1'b1;
            w_rd_addr  = w_win_rd_addr;
            w_sel      = w_win_rd_addr[SEL_LSB +: 2];
            w_cnt      = '0;
          end
        end
      end

      WR: begin
        w_state    = IDLE;
        w_wr_valid = 1'b0;
      end

      RD_WAIT: begin
        if (w_slv_ready) begin
          w_state    = IDLE;
          w_rd_valid = 1'b0;
          if (r_owner) begin
            w_m1_rd_data = w_slv_data;
            w_m1_ack     = 1'b1;
          end else begin
            w_m0_rd_data = w_slv_data;
            w_m0_ack     = 1'b1;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state    = IDLE;
          w_rd_valid = 1'b0;
          if (r_owner) begin
            w_m1_rd_data = ERR_DATA;
            w_m1_ack     = 1'b1;
            w_m1_err     = 1'b1;
          end else begin
            w_m0_rd_data = ERR_DATA;
            w_m0_ack     = 1'b1;
            w_m0_err     = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      default: begin
        w_state    = IDLE;
        w_wr_valid = 1'b0;
        w_rd_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge c_sys_rst) begin
    if (c_sys_rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_sel        <= '0;
      r_cnt        <= '0;
      r_wr_valid   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rd_addr    <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m1_err     <= 1'b0;
      r_m0_rd_data <= '0;
      r_m1_rd_data <= '0;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_owner      <= w_owner;
      r_sel        <= w_sel;
      r_cnt        <= w_cnt;
      r_wr_valid   <= w_wr_valid;
      r_rd_valid   <= w_rd_valid;
      r_wr_addr    <= w_wr_addr;
      r_wr_data    <= w_wr_data;
      r_rd_addr    <= w_rd_addr;
      r_m0_ack     <= w_m0_ack;
      r_m1_ack     <= w_m1_ack;
      r_m0_err     <= w_m0_err;
      r_m1_err     <= w_m1_err;
      r_m0_rd_data <= w_m0_rd_data;
      r_m1_rd_data <= w_m1_rd_data;
    end
  end

  assign bus.ic0_c_axi_mst_wr_valid = r_wr_valid;
  assign bus.ic0_c_axi_mst_rd_valid = r_rd_valid;
  assign bus.ic0_axi_mst_wr_addr    = r_wr_addr;
  assign bus.ic0_axi_mst_wr_data    = r_wr_data;
  assign bus.ic0_axi_mst_rd_addr    = r_rd_addr;
  assign bus.m0_c_ack               = r_m0_ack;
  assign bus.m1_c_ack               = r_m1_ack;
  assign bus.m0_c_err               = r_m0_err;
  assign bus.m1_c_err               = r_m1_err;
  assign bus.m0_rd_data             = r_m0_rd_data;
  assign bus.m1_rd_data             = r_m1_rd_data;

endmodule
